// File: rtl/control_multiplicador.sv
// Shift-and-add unsigned multiplier controller feeding an external combinational adder.
// One add/shift pair per operand bit; the adder carry is kept in C for one shift.
module control_multiplicador #(
    parameter int ANCHO = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inicio,
    input  logic [ANCHO-1:0]     multiplicando,
    input  logic [ANCHO-1:0]     multiplicador,
    output logic [ANCHO-1:0]     suma_a,
    output logic [ANCHO-1:0]     suma_b,
    output logic [3:0]           control,
    input  logic [ANCHO-1:0]     suma,
    input  logic                 acarreo,
    output logic [2*ANCHO-1:0]   producto,
    output logic                 listo,
    output logic                 ocupado
);

    localparam int CW = $clog2(ANCHO + 1);
    localparam logic [3:0] CTL_SUMA   = 4'b1000;
    localparam logic [3:0] CTL_LIMPIA = 4'b0010;

    typedef enum logic [1:0] {IDLE, SUMA, DESPLAZA, FIN} estado_t;

    estado_t            estado, estado_sig;
    logic [ANCHO-1:0]   a_r, q_r, m_r;
    logic               c_r;
    logic [CW-1:0]      cnt;
    logic [2*ANCHO-1:0] prod_r;
    logic               ultimo;

    assign ultimo = (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) estado <= IDLE;
        else     estado <= estado_sig;
    end

    // Adder mode depends only on the state register, so it is stable for the whole cycle.
    always_comb begin
        estado_sig = estado;
        control    = CTL_LIMPIA;
        case (estado)
            IDLE:     if (inicio) estado_sig = SUMA;
            SUMA: begin
                control    = CTL_SUMA;
                estado_sig = DESPLAZA;
            end
            DESPLAZA: estado_sig = ultimo ? FIN : SUMA;
            FIN:      estado_sig = IDLE;
            default:  estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            q_r    <= '0;
            m_r    <= '0;
            c_r    <= 1'b0;
            cnt    <= '0;
            prod_r <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    if (inicio) begin
                        m_r <= multiplicando;
                        q_r <= multiplicador;
                        a_r <= '0;
                        c_r <= 1'b0;
                        cnt <= CW'(ANCHO);
                    end
                end
                SUMA: begin
                    if (q_r[0]) begin
                        a_r <= suma;
                        c_r <= acarreo;
                    end
                end
                DESPLAZA: begin
                    a_r <= {c_r, a_r[ANCHO-1:1]};
                    q_r <= {a_r[0], q_r[ANCHO-1:1]};
                    c_r <= 1'b0;
                    cnt <= cnt - CW'(1);
                    // Capture the shifted result now so it is valid alongside listo.
                    if (ultimo) prod_r <= {c_r, a_r, q_r[ANCHO-1:1]};
                end
                default: ;
            endcase
        end
    end

    assign suma_a   = a_r;
    assign suma_b   = m_r;
    assign producto = prod_r;
    assign listo    = (estado == FIN);
    assign ocupado  = (estado == SUMA) || (estado == DESPLAZA);

endmodule

// File: tb/tb_control_multiplicador.sv
// Bench for control_multiplicador: behavioural adder, arithmetic reference model checked
// every cycle, plus directed operations with hand-computed results.
module tb_control_multiplicador;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           inicio = 1'b0;
    logic [N-1:0]   multiplicando = '0;
    logic [N-1:0]   multiplicador = '0;
    logic [N-1:0]   suma_a, suma_b, suma;
    logic [3:0]     control;
    logic           acarreo;
    logic [2*N-1:0] producto;
    logic           listo, ocupado;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    control_multiplicador #(.ANCHO(N)) dut (
        .clk(clk), .rst(rst), .inicio(inicio),
        .multiplicando(multiplicando), .multiplicador(multiplicador),
        .suma_a(suma_a), .suma_b(suma_b), .control(control),
        .suma(suma), .acarreo(acarreo),
        .producto(producto), .listo(listo), .ocupado(ocupado)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational adder stage: adds in mode 1000, outputs zero otherwise.
    logic [N:0] sum_full;
    assign sum_full = (control == 4'b1000) ? ({1'b0, suma_a} + {1'b0, suma_b}) : '0;
    assign suma     = sum_full[N-1:0];
    assign acarreo  = sum_full[N];

    // Reference model: ph=0 idle, 1..2N busy cycles, 2N+1 done cycle.
    int ph = 0, mm = 0, mq = 0, mprod = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 0; mm <= 0; mq <= 0; mprod <= 0;
        end else if (ph == 0) begin
            if (inicio) begin
                ph <= 1;
                mm <= int'(multiplicando);
                mq <= int'(multiplicador);
            end
        end else if (ph == 2*N+1) begin
            ph <= 0;
        end else begin
            ph <= ph + 1;
            if (ph == 2*N) mprod <= mm * mq;
        end
    end

    // Partial product of M with the low k bits of Q.
    function automatic int part(input int m, input int q, input int k);
        return m * (q & ((1 << k) - 1));
    endfunction

    // Accumulator contents: during iteration k it holds the partial product scaled down by 2^k.
    function automatic int exp_a(input int p, input int m, input int q);
        int k;
        if (p >= 1 && p <= 2*N) begin
            k = (p - 1) / 2;
            if (p % 2 == 1) return (part(m, q, k) >> k) & ((1 << N) - 1);
            else            return (part(m, q, k + 1) >> k) & ((1 << N) - 1);
        end
        return (m * q) >> N;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_producto", int'(producto), mprod);
        chk("m_listo",    int'(listo),    (ph == 2*N+1) ? 1 : 0);
        chk("m_ocupado",  int'(ocupado),  (ph >= 1 && ph <= 2*N) ? 1 : 0);
        chk("m_control",  int'(control),  (ph >= 1 && ph <= 2*N && ph % 2 == 1) ? 8 : 2);
        chk("m_suma_a",   int'(suma_a),   exp_a(ph, mm, mq));
        chk("m_suma_b",   int'(suma_b),   mm);
    end

    // Starts an operation and follows it until listo (bounded). rel = edges from start edge to listo.
    task automatic run_op(input int a, input int b, input bit hold, input int ca, input int cb,
                          output int rel, output int abs_c, output int busy, output int adds);
        @(negedge clk);
        multiplicando = N'(a);
        multiplicador = N'(b);
        inicio = 1'b1;
        @(posedge clk);
        rel = -1; abs_c = -1; busy = 0; adds = 0;
        for (int i = 1; i <= 40 && rel < 0; i++) begin
            @(negedge clk);
            if (!hold) inicio = 1'b0;
            if (hold && i == 5) begin
                multiplicando = N'(ca);
                multiplicador = N'(cb);
            end
            if (ocupado) busy++;
            if (control == 4'b1000) adds++;
            if (listo) begin
                rel = i - 1;
                abs_c = cyc;
            end
        end
        if (rel < 0) chk("listo_timeout", 0, 1);
    endtask

    initial begin
        int rel, abs1, abs2, busy, adds, nl;

        @(negedge clk);
        chk("rst_producto", int'(producto), 0);
        chk("rst_control",  int'(control),  2);
        chk("rst_ocupado",  int'(ocupado),  0);
        chk("rst_listo",    int'(listo),    0);
        rst = 1'b0;

        run_op(3, 5, 1'b0, 0, 0, rel, abs1, busy, adds);
        chk("basic_prod",  int'(producto), 15);
        chk("basic_edges", rel,  16);
        chk("basic_busy",  busy, 16);

        run_op(255, 255, 1'b0, 0, 0, rel, abs1, busy, adds);
        chk("carry_prod", int'(producto), 16'hFE01);
        chk("carry_adds", adds, 8);

        run_op(0, 200, 1'b0, 0, 0, rel, abs1, busy, adds);
        chk("zero_prod", int'(producto), 0);
        run_op(200, 1, 1'b0, 0, 0, rel, abs1, busy, adds);
        chk("ident_prod_a", int'(producto), 200);
        run_op(1, 200, 1'b0, 0, 0, rel, abs1, busy, adds);
        chk("ident_prod_b", int'(producto), 200);

        // inicio held high throughout, operands changed mid-operation to 7 and 6.
        run_op(12, 10, 1'b1, 7, 6, rel, abs1, busy, adds);
        chk("hold_prod1", int'(producto), 120);
        @(negedge clk);
        chk("hold_idle_gap", int'(ocupado), 0);
        @(negedge clk);
        chk("hold_restart", int'(ocupado), 1);
        inicio = 1'b0;
        abs2 = -1;
        for (int i = 0; i < 40 && abs2 < 0; i++) begin
            @(negedge clk);
            if (listo) abs2 = cyc;
        end
        if (abs2 < 0) chk("hold_timeout", 0, 1);
        chk("hold_prod2",  int'(producto), 42);
        chk("hold_period", abs2 - abs1, 18);

        // Reset during the 6th busy cycle of 7x9.
        @(negedge clk);
        multiplicando = 8'd7;
        multiplicador = 8'd9;
        inicio = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            inicio = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        chk("abort_producto", int'(producto), 0);
        chk("abort_ocupado",  int'(ocupado),  0);
        chk("abort_listo",    int'(listo),    0);
        chk("abort_control",  int'(control),  2);
        chk("abort_suma_a",   int'(suma_a),   0);
        chk("abort_suma_b",   int'(suma_b),   0);
        nl = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            if (listo) nl++;
        end
        chk("abort_no_listo", nl, 0);
        run_op(7, 9, 1'b0, 0, 0, rel, abs1, busy, adds);
        chk("abort_retry_prod", int'(producto), 63);

        // Back-to-back operations.
        run_op(100, 100, 1'b0, 0, 0, rel, abs1, busy, adds);
        chk("b2b_prod1", int'(producto), 10000);
        run_op(2, 3, 1'b0, 0, 0, rel, abs2, busy, adds);
        chk("b2b_prod2",  int'(producto), 6);
        chk("b2b_period", abs2 - abs1, 18);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
